// File: rtl/draw_circle_pkg.sv
// Shared widths, pipeline latency and the per-pixel timing bundle for the circle overlay.
package draw_circle_pkg;

    localparam int PIX_W = 12;
    localparam int RGB_W = 12;
    localparam int LAT   = 3;
    localparam int D2_W  = 25;

    // Coordinates, sync/blank flags and upstream colour travel together down the delay line.
    typedef struct packed {
        logic [PIX_W-1:0] hcount;
        logic [PIX_W-1:0] vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
        logic [RGB_W-1:0] rgb;
    } pix_t;

    // Elaboration-time square used for the radius limits.
    function automatic logic [D2_W-1:0] sq_const(input int v);
        return D2_W'(v * v);
    endfunction

endpackage

// File: rtl/circle_hit.sv
// One circle's hit test: |d| register, square register, then a combinational
// compare so the hit lines up with the third pipeline stage of the top level.
module circle_hit
    import draw_circle_pkg::*;
#(
    parameter logic [D2_W-1:0] R2        = 25'd400,
    parameter logic [D2_W-1:0] INNER2    = 25'd0,
    parameter bit              USE_INNER = 1'b0
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [PIX_W-1:0] hcount_in,
    input  logic [PIX_W-1:0] vcount_in,
    input  logic [PIX_W-1:0] x_in,
    input  logic [PIX_W-1:0] y_in,
    input  logic             en_in,
    output logic             hit_out
);

    logic [PIX_W-1:0]   adx_d, adx_q, ady_d, ady_q;
    logic [2*PIX_W-1:0] dx2_d, dx2_q, dy2_d, dy2_q;
    logic               en1_d, en1_q, en2_d, en2_q;
    logic signed [PIX_W:0] dx, dy;
    logic [D2_W-1:0]    d2;

    // Signed 13-bit differences so a pixel left/above the centre never wraps.
    always_comb begin
        dx    = $signed({1'b0, hcount_in}) - $signed({1'b0, x_in});
        dy    = $signed({1'b0, vcount_in}) - $signed({1'b0, y_in});
        adx_d = dx[PIX_W] ? PIX_W'(-dx) : dx[PIX_W-1:0];
        ady_d = dy[PIX_W] ? PIX_W'(-dy) : dy[PIX_W-1:0];
        en1_d = en_in;
        dx2_d = (2*PIX_W)'(adx_q) * (2*PIX_W)'(adx_q);
        dy2_d = (2*PIX_W)'(ady_q) * (2*PIX_W)'(ady_q);
        en2_d = en1_q;
    end

    // Stage registers; the enable rides along so it matches the pixel it was sampled with.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            adx_q <= '0;
            ady_q <= '0;
            en1_q <= 1'b0;
            dx2_q <= '0;
            dy2_q <= '0;
            en2_q <= 1'b0;
        end else begin
            adx_q <= adx_d;
            ady_q <= ady_d;
            en1_q <= en1_d;
            dx2_q <= dx2_d;
            dy2_q <= dy2_d;
            en2_q <= en2_d;
        end
    end

    // Distance compare; the ring variant also rejects the inner disc.
    always_comb begin
        d2      = {1'b0, dx2_q} + {1'b0, dy2_q};
        hit_out = en2_q && (d2 <= R2) && (!USE_INNER || (d2 > INNER2));
    end

endmodule

// File: rtl/draw_circle_pipe.sv
// Multi-circle overlay: per-frame shadowed centres, one hit pipeline per circle,
// matching delay line for timing/colour, lowest index wins.
module draw_circle_pipe
    import draw_circle_pkg::*;
#(
    parameter int N_CIRCLES = 2,
    parameter int RADIUS    = 20,
    parameter int OUTLINE   = 0,
    parameter int RING_W    = 3,
    parameter logic [RGB_W*N_CIRCLES-1:0] COLORS = {12'h0ff, 12'hfff}
) (
    input  logic                         clk_in,
    input  logic                         rst,
    input  logic [PIX_W-1:0]             hcount_in,
    input  logic [PIX_W-1:0]             vcount_in,
    input  logic                         hsync_in,
    input  logic                         vsync_in,
    input  logic                         hblnk_in,
    input  logic                         vblnk_in,
    input  logic [RGB_W-1:0]             rgb_in,
    input  logic [PIX_W*N_CIRCLES-1:0]   xpos_in,
    input  logic [PIX_W*N_CIRCLES-1:0]   ypos_in,
    input  logic [N_CIRCLES-1:0]         en_in,
    output logic [PIX_W-1:0]             hcount_out,
    output logic [PIX_W-1:0]             vcount_out,
    output logic                         hsync_out,
    output logic                         vsync_out,
    output logic                         hblnk_out,
    output logic                         vblnk_out,
    output logic [RGB_W-1:0]             rgb_out,
    output logic [PIX_W*N_CIRCLES-1:0]   xpos_out,
    output logic [PIX_W*N_CIRCLES-1:0]   ypos_out
);

    localparam logic [D2_W-1:0] R2     = sq_const(RADIUS);
    localparam logic [D2_W-1:0] INNER2 = sq_const(RADIUS - RING_W);

    logic [PIX_W*N_CIRCLES-1:0] xsh_d, xsh_q, ysh_d, ysh_q;
    logic [N_CIRCLES-1:0]       ensh_d, ensh_q;
    logic                       vblnk_prev_d, vblnk_prev_q;
    pix_t                       pipe_d [LAT-1];
    pix_t                       pipe_q [LAT-1];
    pix_t                       out_d, out_q;
    logic [N_CIRCLES-1:0]       hit;

    // Shadows reload only on the rising edge of vertical blank, so a frame never tears.
    always_comb begin
        vblnk_prev_d = vblnk_in;
        xsh_d        = xsh_q;
        ysh_d        = ysh_q;
        ensh_d       = ensh_q;
        if (vblnk_in && !vblnk_prev_q) begin
            xsh_d  = xpos_in;
            ysh_d  = ypos_in;
            ensh_d = en_in;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CIRCLES; gi++) begin : g_hit
            circle_hit #(
                .R2        (R2),
                .INNER2    (INNER2),
                .USE_INNER (OUTLINE != 0)
            ) u_hit (
                .clk_in    (clk_in),
                .rst       (rst),
                .hcount_in (hcount_in),
                .vcount_in (vcount_in),
                .x_in      (xsh_q[PIX_W*gi +: PIX_W]),
                .y_in      (ysh_q[PIX_W*gi +: PIX_W]),
                .en_in     (ensh_q[gi]),
                .hit_out   (hit[gi])
            );
        end
    endgenerate

    // Delay line plus priority mux; scanning from the top index down lets circle 0 win.
    always_comb begin
        pipe_d[0] = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                      vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};
        for (int i = 1; i < LAT - 1; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        out_d = pipe_q[LAT-2];
        for (int i = N_CIRCLES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                out_d.rgb = COLORS[RGB_W*i +: RGB_W];
            end
        end
    end

    // All state clears on reset, which also beats a coincident vblank edge.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            xsh_q        <= '0;
            ysh_q        <= '0;
            ensh_q       <= '0;
            vblnk_prev_q <= 1'b0;
            pipe_q       <= '{default: '0};
            out_q        <= '0;
        end else begin
            xsh_q        <= xsh_d;
            ysh_q        <= ysh_d;
            ensh_q       <= ensh_d;
            vblnk_prev_q <= vblnk_prev_d;
            pipe_q       <= pipe_d;
            out_q        <= out_d;
        end
    end

    assign hcount_out = out_q.hcount;
    assign vcount_out = out_q.vcount;
    assign hsync_out  = out_q.hsync;
    assign vsync_out  = out_q.vsync;
    assign hblnk_out  = out_q.hblnk;
    assign vblnk_out  = out_q.vblnk;
    assign rgb_out    = out_q.rgb;
    assign xpos_out   = xsh_q;
    assign ypos_out   = ysh_q;

endmodule

// File: doc/draw_circle_pipe.md
# draw_circle_pipe

Parametrised, pipelined successor to the single-stage two-player circle overlay. Draws up to `N_CIRCLES` circles, filled or outline, over the incoming VGA pixel stream, with a fixed priority between circles. Circle positions are latched once per frame, so a circle never tears mid-frame. Sits in the VGA chain between the background/field renderer and the pixel output stage; all timing signals are delayed to match the pixel pipeline.

## Interface
Parameters:
- `N_CIRCLES`, 2: number of circles; valid range 1..8.
- `RADIUS`, 20: circle radius in pixels, same for all circles; valid range 1..255.
- `OUTLINE`, 0: 0 = filled disc; 1 = ring of width `RING_W`.
- `RING_W`, 3: ring thickness in pixels, used when `OUTLINE`=1; must be < `RADIUS`.
- `COLORS`, {12'h0ff, 12'hfff}: packed 12·N colour vector; circle i uses bits [12i+11:12i].

Ports (one clock; reset is synchronous and active-high):
- `clk_in` in 1: pixel clock.
- `rst` in 1: synchronous active-high reset.
- `hcount_in`, `vcount_in` in 12: pixel coordinates.
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in` in 1: timing signals.
- `rgb_in` in 12: upstream pixel colour.
- `xpos_in`, `ypos_in` in 12·N: circle centres; circle i uses slice i.
- `en_in` in N: per-circle enable.
- `hcount_out`, `vcount_out` out 12: coordinates delayed by `LAT`.
- `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out` out 1: timing signals delayed by `LAT`.
- `rgb_out` out 12: composited pixel.
- `xpos_out`, `ypos_out` out 12·N: latched (shadow) centres.

## Operation
- Shadow registers: `xpos_in`, `ypos_in` and `en_in` are captured into shadows on the cycle where `vblnk_in`=1 and the previous sampled `vblnk_in`=0 (rising edge of vertical blank). All hit tests use the shadows. `xpos_out`/`ypos_out` expose the shadows.
- Per circle i, pipeline stages:
  - S1: dx = hcount − x_i and dy = vcount − y_i, computed as 13-bit signed; store |dx|, |dy| as 12 bits. There is no modular wrap: hcount=0 with x=5 gives |dx|=5.
  - S2: dx², dy², each 24-bit unsigned.
  - S3: d2 = dx²+dy², 25-bit. Hit when en_i=1 and d2 ≤ R². If `OUTLINE`=1, additionally require d2 > (R−RING_W)².
- Priority: the lowest-index circle that hits wins. If no circle hits, `rgb_in` (delayed) passes through unchanged.
- Blanking: the module does not modify `rgb_in` semantics. Hits during blanking still override, matching the existing overlay behaviour; the upstream stage zeros blank pixels.
- Constants R², (R−RING_W)² are elaboration-time 25-bit values.

## Timing
- `LAT` = 3 cycles for every `*_out` except `xpos_out`/`ypos_out`. `rgb_out` at cycle t+3 corresponds to the inputs at cycle t. `rgb_in` and all timing signals are delayed by the same 3 stages.
- Shadow update takes effect on the first pixel sampled after the capture edge; `xpos_out`/`ypos_out` change 1 cycle after that edge.
- Inputs that change mid-frame are ignored until the next vblank rising edge.
- Reset: every output register, every pipeline register and every shadow goes to 0, and the `vblnk` edge detector's previous value goes to 0. With `rst` held, the outputs stay 0. After reset deassertion, the first valid output appears 3 cycles later, and shadows stay 0 until the first vblank edge.
- Reset asserted mid-line flushes the pipeline; there are no partial pixels afterwards.
- A vblank edge and reset in the same cycle: reset wins.

## Structure
- Package `draw_circle_pkg`: `PIX_W`=12, `RGB_W`=12, `LAT`=3, `D2_W`=25.
- Sub-module `circle_hit`: one instance per circle via generate. It contains the 3-stage |d|/square/compare pipeline, takes R² and the inner limit as parameters, and outputs a 1-bit hit aligned to S3.
- The top level holds the shadows, the vblank edge detector, the delay lines and the priority mux.

## Test plan
- Reset: assert `rst` with random inputs → all outputs 0; deassert → `rgb_out` equals `rgb_in` from 3 cycles earlier when there is no hit.
- Edge and diagonal: circle at (100,100), R=20 → (120,100) hit, (121,100) miss, (114,114) hit (d2=392), (115,114) miss (d2=421), each 3 cycles later.
- Underflow: circle at (5,5), pixel (0,0) → hit. Pixel (4090,5) with x=5 → miss (no wrap).
- Priority and enable: circles 0 and 1 both at (200,200) → colour 0. Set `en_in`[0]=0 and pass a vblank edge → colour 1.
- Frame latch: move circle 0 from (100,100) to (300,300) mid-frame → pixel (100,100) is still hit until the vblank rising edge, then (300,300) is hit.
- Outline (`OUTLINE`=1, `RING_W`=3, R=20): (117,100) → d2=289 = 17², miss. (118,100) → d2=324, hit. (120,100) → hit.
